buzzer_arbiter: RTL
===================

// Module: buzzer_arbiter
// PURPOSE
//  Arbitrates the answer right for one question among up to 4 contestants in the quiz/competition flow.
//  Detects false starts before the host opens buzzing and grants exactly one player per window.
//  Uses round-robin priority to resolve simultaneous buzzes, runs the per-answer countdown, and
//  re-opens buzzing after a wrong answer. Sits between the key/button edge detectors and the
//  scoring/display logic, and hands over a one-cycle per-question result.
// PARAMETERS
//  TICKS_PER_MS  100_000  clk cycles per 1 ms countdown tick (100 MHz board clock)
// PORTS
//  clk           in   1   system clock; all logic on posedge
//  rst           in   1   reset, synchronous, active-high
//  enable        in   1   competition view active; while low, block behaves exactly as under rst
//  player_count  in   3   active players; <2 treated as 2, >4 treated as 4
//  answer_time   in   7   seconds per window; 0 treated as 1
//  open          in   1   1-cycle host pulse: open buzzing for the current question
//  buzz          in   4   1-cycle buzz edges; bit i = player i+1
//  judge_ok      in   1   1-cycle pulse: granted player answered correctly
//  judge_fail    in   1   1-cycle pulse: granted player answered wrongly
//  judge_skip    in   1   1-cycle pulse: host abandons question
//  state         out  2   0 IDLE, 1 ARMED, 2 GRANTED, 3 DONE
//  grant         out  3   0 none, else granted player 1..4
//  time_remain   out  17  ms left in current window (max 127000)
//  false_start   out  4   per-player flag: buzzed in IDLE this question
//  locked        out  4   per-player flag: barred for rest of this question
//  result        out  2   0 none, 1 ok, 2 all failed, 3 timeout/skip; held until next DONE
//  result_valid  out  1   1-cycle pulse on entry to DONE
// BEHAVIOUR
//  Reset (rst or !enable):
//  - All outputs are 0; state = IDLE.
//  - rr_ptr = 0 (player 1 highest priority); ms divider is cleared.
//  Valid mask: players above player_count never set flags and are never granted.
//  IDLE:
//  - A valid buzz[i] sets false_start[i] and locked[i].
//  - open -> ARMED; load time_remain = answer_time*1000; clear divider.
//  ARMED:
//  - elig = buzz & valid & ~locked.
//  - elig != 0: grant the first set bit searching from rr_ptr upward with wrap; rr_ptr = winner+1
//    (mod 4); state -> GRANTED; reload timer.
//  - elig == 0 and no valid unlocked player remains: -> DONE, result 3.
//  GRANTED:
//  - Buzzes are ignored.
//  - judge_ok: -> DONE, result 1.
//  - judge_skip: -> DONE, result 3.
//  - judge_fail, or timer expiry: set locked[grant-1]; grant = 0. If any valid player is still
//    unlocked -> ARMED with timer reload; else -> DONE, result 2.
//  - More than one judge pulse in the same cycle: all are ignored.
//  DONE:
//  - Lasts exactly 1 cycle, during which result_valid = 1.
//  - Next cycle -> IDLE; clear grant, locked, false_start; rr_ptr and result are kept.
//  Timer:
//  - Divider pulses a tick every TICKS_PER_MS cycles, only in ARMED/GRANTED.
//  - On each tick, time_remain decrements.
//  - Expiry = tick while time_remain == 1. time_remain becomes 0 and the transition happens on the
//    same edge.
//  - In ARMED, expiry -> DONE, result 3.
//  - time_remain holds its value in IDLE/DONE; reloading is done by open/grant only.
//  Priorities and ignored inputs:
//  - Same-cycle buzz vs expiry in ARMED: the buzz wins.
//  - Same-cycle judge vs expiry in GRANTED: the judge wins.
//  - open outside IDLE is ignored.
//  - judge_* outside GRANTED are ignored.
//  Arithmetic: answer_time*1000 is computed at 17 bits, so there is no overflow.
// TESTING (TICKS_PER_MS=4)
//  1 pc=4, open, buzz=0110 -> grant=2. judge_ok -> result=1 with 1-cycle result_valid. Next
//    question buzz=0110 -> grant=3.
//  2 IDLE buzz=0001 -> false_start=0001, locked=0001. open, buzz=0001 -> state stays 1. Then
//    buzz=0010 -> grant=2.
//  3 pc=2: grant 1, judge_fail -> locked=01, state=1, time reloaded. Then grant 2, judge_fail ->
//    state=3, result=2.
//  4 answer_time=1, open, no buzz -> time_remain steps 1000..0 every 4 cycles. DONE at cycle 4000,
//    result=3.
//  5 pc=3, buzz=1000 in IDLE and in ARMED -> no flags, no grant. judge_ok|judge_fail in the same
//    cycle -> state unchanged.
//  6 rst (and separately enable=0) during GRANTED -> next cycle all outputs 0, state=0. Then
//    buzz=1111 in ARMED -> grant=1.

Source files
------------

// File: rtl/buzzer_if.sv
// Buzzer arbiter bus: host/player controls in, arbitration status out.
// master drives the controls, slave is the arbiter.
interface buzzer_if;
    logic        enable;
    logic [2:0]  player_count;
    logic [6:0]  answer_time;
    logic        open;
    logic [3:0]  buzz;
    logic        judge_ok;
    logic        judge_fail;
    logic        judge_skip;
    logic [1:0]  state;
    logic [2:0]  grant;
    logic [16:0] time_remain;
    logic [3:0]  false_start;
    logic [3:0]  locked;
    logic [1:0]  result;
    logic        result_valid;

    modport master (
        output enable, player_count, answer_time,
        output open, buzz, judge_ok, judge_fail, judge_skip,
        input  state, grant, time_remain,
        input  false_start, locked, result, result_valid
    );

    modport slave (
        input  enable, player_count, answer_time,
        input  open, buzz, judge_ok, judge_fail, judge_skip,
        output state, grant, time_remain,
        output false_start, locked, result, result_valid
    );
endinterface

// File: rtl/buzzer_arbiter.sv
// Quiz buzzer arbiter: false-start detection, round-robin grant,
// per-answer ms countdown and one-cycle per-question result.
module buzzer_arbiter #(
    parameter int TICKS_PER_MS = 100_000
) (
    input  logic     clk,
    input  logic     rst,
    buzzer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        GRANTED = 2'd2,
        DONE    = 2'd3
    } st_t;

    localparam int DW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICKS_PER_MS - 1);

    st_t         st;
    logic [DW-1:0] div;
    logic [1:0]  rr_ptr;
    logic [2:0]  grant;
    logic [16:0] tr;
    logic [3:0]  fs;
    logic [3:0]  lk;
    logic [1:0]  res;
    logic        rv;

    logic [3:0]  valid;
    logic [6:0]  at_eff;
    logic [16:0] load;
    logic        tick;
    logic        expire;
    logic [3:0]  elig;
    logic [1:0]  win;
    logic [1:0]  idx;
    logic        found;
    logic [3:0]  lk_fail;
    logic [1:0]  jn;
    logic        fail_ev;

    always_comb begin
        valid = 4'b1111;
        unique case (1'b1)
            (bus.player_count <= 3'd2): valid = 4'b0011;
            (bus.player_count == 3'd3): valid = 4'b0111;
            (bus.player_count >= 3'd4): valid = 4'b1111;
        endcase
    end

    assign at_eff = (bus.answer_time == 7'd0) ? 7'd1 : bus.answer_time;
    assign load   = {10'd0, at_eff} * 17'd1000;

    assign tick   = ((st == ARMED) || (st == GRANTED)) && (div == DIV_LAST);
    assign expire = tick && (tr == 17'd1);

    assign elig = bus.buzz & valid & ~lk;

    // Round-robin: first eligible player at or after rr_ptr, wrapping.
    always_comb begin
        win   = rr_ptr;
        idx   = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && elig[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        lk_fail = lk;
        lk_fail[grant[1:0] - 2'd1] = 1'b1;
    end

    assign jn = {1'b0, bus.judge_ok} + {1'b0, bus.judge_fail}
              + {1'b0, bus.judge_skip};

    // Conflicting judge pulses count as none; expiry then still applies.
    assign fail_ev = ((jn == 2'd1) && bus.judge_fail)
                   || ((jn != 2'd1) && expire);

    always_ff @(posedge clk) begin
        if (rst || !bus.enable) begin
            st     <= IDLE;
            div    <= '0;
            rr_ptr <= 2'd0;
            grant  <= 3'd0;
            tr     <= 17'd0;
            fs     <= 4'd0;
            lk     <= 4'd0;
            res    <= 2'd0;
            rv     <= 1'b0;
        end else begin
            rv <= 1'b0;
            if ((st == ARMED) || (st == GRANTED)) begin
                div <= tick ? '0 : div + 1'b1;
                if (tick && (tr != 17'd0))
                    tr <= tr - 1'b1;
            end
            unique case (st)
                IDLE: begin
                    fs <= fs | (bus.buzz & valid);
                    lk <= lk | (bus.buzz & valid);
                    if (bus.open) begin
                        st  <= ARMED;
                        tr  <= load;
                        div <= '0;
                    end
                end
                ARMED: begin
                    if (|elig) begin
                        grant  <= {1'b0, win} + 3'd1;
                        rr_ptr <= win + 2'd1;
                        st     <= GRANTED;
                        tr     <= load;
                        div    <= '0;
                    end else if (!(|(valid & ~lk)) || expire) begin
                        st  <= DONE;
                        res <= 2'd3;
                        rv  <= 1'b1;
                    end
                end
                GRANTED: begin
                    if ((jn == 2'd1) && bus.judge_ok) begin
                        st  <= DONE;
                        res <= 2'd1;
                        rv  <= 1'b1;
                    end else if ((jn == 2'd1) && bus.judge_skip) begin
                        st  <= DONE;
                        res <= 2'd3;
                        rv  <= 1'b1;
                    end else if (fail_ev) begin
                        lk    <= lk_fail;
                        grant <= 3'd0;
                        if (|(valid & ~lk_fail)) begin
                            st  <= ARMED;
                            tr  <= load;
                            div <= '0;
                        end else begin
                            st  <= DONE;
                            res <= 2'd2;
                            rv  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    st    <= IDLE;
                    grant <= 3'd0;
                    lk    <= 4'd0;
                    fs    <= 4'd0;
                end
            endcase
        end
    end

    assign bus.state        = st;
    assign bus.grant        = grant;
    assign bus.time_remain  = tr;
    assign bus.false_start  = fs;
    assign bus.locked       = lk;
    assign bus.result       = res;
    assign bus.result_valid = rv;

endmodule
